// File: rtl/bcd_conv_if.sv
// bcd_conv_if: groups the result-capture inputs and the BCD report outputs of
// the binary-to-BCD converter into one bundle.
//   in_valid  : multiplier done (level or pulse, rising edge is the event)
//   in_data   : 16-bit multiplier product, sampled on the event edge
//   bcd_out   : five packed BCD digits, [19:16] ten-thousands .. [3:0] units
//   out_valid : one-cycle pulse when bcd_out updates
//   busy      : converting or holding a pending result
//   ovf       : sticky flag, a result was dropped
// The master modport is the producer/consumer side, slave is the converter.
interface bcd_conv_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic [19:0] bcd_out;
  logic        out_valid;
  logic        busy;
  logic        ovf;

  modport master (
    output in_valid,
    output in_data,
    input  bcd_out,
    input  out_valid,
    input  busy,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output bcd_out,
    output out_valid,
    output busy,
    output ovf
  );
endinterface

// File: rtl/bcd_conv.sv
// bcd_conv: sequential 16-bit binary to 5-digit BCD converter using the
// shift-and-add-3 (double-dabble) algorithm, one bit per clock. A rising edge
// of in_valid captures in_data; one result can wait in a holding register
// while a conversion is running, any further one is dropped and flagged.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : bcd_conv_if.slave (in_valid, in_data, bcd_out, out_valid, busy, ovf)
module bcd_conv (
  input  logic       clk,
  input  logic       rst,
  bcd_conv_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // Add 3 to every BCD digit that is 5 or more, so the following shift
  // carries correctly into the next digit.
  function automatic logic [19:0] add3_digits(input logic [19:0] acc);
    logic [19:0] res;
    res = acc;
    for (int i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return res;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic        pend_q, pend_d;
  logic        prev_q;
  logic [19:0] bcd_out_q, bcd_out_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;

  logic        event_s;
  logic [19:0] adj_s;
  logic [35:0] shift_s;

  assign event_s = bus.in_valid & ~prev_q;
  assign adj_s   = add3_digits(acc_q);
  // Bit 19 of the adjusted accumulator is always 0 for 16-bit inputs.
  assign shift_s = {adj_s[18:0], bin_q, 1'b0};

  assign bus.bcd_out   = bcd_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.ovf       = ovf_q;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bin_q       <= 16'd0;
      acc_q       <= 20'd0;
      cnt_q       <= 4'd0;
      hold_q      <= 16'd0;
      pend_q      <= 1'b0;
      prev_q      <= 1'b0;
      bcd_out_q   <= 20'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
      prev_q      <= bus.in_valid;
      bcd_out_q   <= bcd_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  // Next-state logic: event capture, conversion step, completion hand-off.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    pend_d      = pend_q;
    bcd_out_d   = bcd_out_q;
    out_valid_d = 1'b0;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (event_s) begin
          bin_d   = bus.in_data;
          acc_d   = 20'd0;
          cnt_d   = 4'd0;
          state_d = ST_CONV;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CONV: begin
        acc_d = shift_s[35:16];
        bin_d = shift_s[15:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          bcd_out_d   = shift_s[35:16];
          out_valid_d = 1'b1;
          if (pend_q) begin
            // Pending result starts now; a coincident event refills the hold.
            bin_d = hold_q;
            acc_d = 20'd0;
            cnt_d = 4'd0;
            if (event_s) begin
              hold_d = bus.in_data;
              pend_d = 1'b1;
            end else begin
              pend_d = 1'b0;
            end
          end else if (event_s) begin
            bin_d = bus.in_data;
            acc_d = 20'd0;
            cnt_d = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (event_s) begin
            if (!pend_q) begin
              hold_d = bus.in_data;
              pend_d = 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            pend_d = pend_q;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CONV) | pend_d;
  end

endmodule

// File: tb/tb_bcd_conv.sv
// tb_bcd_conv: self-checking bench for bcd_conv. Expected BCD values and the
// edge on which each result must appear go into a scoreboard queue when the
// stimulus is driven; a negedge monitor pops and compares on every out_valid.
module tb_bcd_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_conv_if bif ();

  bcd_conv dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct {
    logic [19:0] bcd;
    int          due;
  } exp_t;

  typedef struct {
    logic [15:0] din;
    logic [19:0] exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   pulse_cnt = 0;

  // Edge counter: after the k-th rising edge cyc equals k.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference conversion by repeated division.
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int t;
    r = 20'd0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [19:0] b, input int due);
    exp_t e;
    e.bcd = b;
    e.due = due;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; makes in_valid rise so edge number 'target' samples it.
  task automatic pulse_at(input int target, input logic [15:0] d);
    while (cyc < target - 1) @(negedge clk);
    bif.in_valid = 1'b1;
    bif.in_data  = d;
    @(negedge clk);
    bif.in_valid = 1'b0;
    bif.in_data  = 16'($urandom);
  endtask

  task automatic drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout with %0d results outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Output monitor: every out_valid must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bif.out_valid === 1'b1) begin
      pulse_cnt++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got pulse with bcd_out 0x%0h at cycle %0d, required none", bif.bcd_out, cyc);
      end else begin
        e = sb_q.pop_front();
        check("bcd_out", 32'(bif.bcd_out), 32'(e.bcd));
        check("out_valid_edge", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    int t;
    int p0;

    bif.in_valid = 1'b0;
    bif.in_data  = 16'd0;

    vecs[0] = '{din: 16'h0993, exp: 20'h02451};
    vecs[1] = '{din: 16'h31B0, exp: 20'h12720};
    vecs[2] = '{din: 16'hFFFF, exp: 20'h65535};
    vecs[3] = '{din: 16'h0000, exp: 20'h00000};
    vecs[4] = '{din: 16'h0001, exp: 20'h00001};
    vecs[5] = '{din: 16'h270F, exp: 20'h09999};
    vecs[6] = '{din: 16'h2710, exp: 20'h10000};
    for (int i = 7; i < 10; i++) begin
      vecs[i].din = 16'($urandom);
      vecs[i].exp = ref_bcd(int'(vecs[i].din));
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_bcd_out", 32'(bif.bcd_out), 32'd0);
    check("rst_out_valid", 32'(bif.out_valid), 32'd0);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_ovf", 32'(bif.ovf), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single conversions from the vector table.
    for (int i = 0; i < 10; i++) begin
      t = cyc + 1;
      push(vecs[i].exp, t + 16);
      pulse_at(t, vecs[i].din);
      check("busy_rise", 32'(bif.busy), 32'd1);
      drain(40, "single_conv");
      repeat (2) @(negedge clk);
      check("busy_idle", 32'(bif.busy), 32'd0);
      check("ovf_clear", 32'(bif.ovf), 32'd0);
    end

    // Level-high in_valid gives exactly one event.
    p0 = pulse_cnt;
    t  = cyc + 1;
    push(20'h02451, t + 16);
    bif.in_valid = 1'b1;
    bif.in_data  = 16'h0993;
    repeat (600) @(negedge clk);
    check("level_one_pulse", 32'(pulse_cnt - p0), 32'd1);
    bif.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    t = cyc + 1;
    push(20'h12720, t + 16);
    pulse_at(t, 16'h31B0);
    drain(40, "level_rearm");
    check("level_rearm_pulses", 32'(pulse_cnt - p0), 32'd2);
    repeat (2) @(negedge clk);

    // Three events at E0, E3, E5: second is held, third dropped.
    t = cyc + 1;
    push(20'h00001, t + 16);
    push(20'h00002, t + 32);
    pulse_at(t, 16'h0001);
    pulse_at(t + 3, 16'h0002);
    check("ovf_before_drop", 32'(bif.ovf), 32'd0);
    pulse_at(t + 5, 16'h0003);
    check("ovf_set", 32'(bif.ovf), 32'd1);
    check("busy_pending", 32'(bif.busy), 32'd1);
    drain(60, "three_events");
    repeat (3) @(negedge clk);
    check("ovf_sticky", 32'(bif.ovf), 32'd1);
    check("busy_after_three", 32'(bif.busy), 32'd0);

    // Event exactly on the completion edge, pending clear: no idle gap.
    t = cyc + 1;
    push(ref_bcd(32'h1234), t + 16);
    push(ref_bcd(32'h0042), t + 32);
    pulse_at(t, 16'h1234);
    pulse_at(t + 16, 16'h0042);
    check("busy_restart", 32'(bif.busy), 32'd1);
    drain(40, "completion_edge");
    repeat (2) @(negedge clk);
    check("busy_after_restart", 32'(bif.busy), 32'd0);

    // Reset in the middle of a conversion aborts it.
    t = cyc + 1;
    pulse_at(t, 16'h0993);
    while (cyc < t + 8) @(negedge clk);
    p0 = pulse_cnt;
    rst = 1'b1;
    #1;
    check("abort_bcd_out", 32'(bif.bcd_out), 32'd0);
    check("abort_out_valid", 32'(bif.out_valid), 32'd0);
    check("abort_busy", 32'(bif.busy), 32'd0);
    check("abort_ovf", 32'(bif.ovf), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    t = cyc + 1;
    push(20'h12720, t + 16);
    pulse_at(t, 16'h31B0);
    drain(40, "after_abort");
    repeat (2) @(negedge clk);
    check("after_abort_busy", 32'(bif.busy), 32'd0);
    check("after_abort_ovf", 32'(bif.ovf), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
